// File: rtl/bfp_pkg.sv
// Shared types and default sizing for the BFP group sequencer and converter.
package bfp_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int unsigned DEF_GRPSIZE    = 16;
  localparam int unsigned DEF_FPEXPSIZE  = 8;
  localparam int unsigned DEF_FPMANSIZE  = 23;
  localparam int unsigned DEF_BFPEXPSIZE = 8;
  localparam int unsigned DEF_BFPMANSIZE = 3;

  // Largest exponent stored in the buffer; keeps max+1 from wrapping to zero.
  localparam int unsigned EXP_MAX = 2 ** DEF_FPEXPSIZE - 2;

endpackage

// File: rtl/bfp_converter.sv
// Combinational FP-to-BFP group converter: shared exponent is max+1, each
// element's hidden-one significand is right-shifted by its distance from max.
module bfp_converter
  import bfp_pkg::*;
#(
  parameter int unsigned GRPSIZE    = DEF_GRPSIZE,
  parameter int unsigned FPEXPSIZE  = DEF_FPEXPSIZE,
  parameter int unsigned FPMANSIZE  = DEF_FPMANSIZE,
  parameter int unsigned BFPEXPSIZE = DEF_BFPEXPSIZE,
  parameter int unsigned BFPMANSIZE = DEF_BFPMANSIZE
) (
  input  logic [GRPSIZE-1:0][FPEXPSIZE-1:0]  exps,
  input  logic [GRPSIZE-1:0][FPMANSIZE:0]    mans,
  output logic [BFPEXPSIZE-1:0]              bfp_exp,
  output logic [GRPSIZE-1:0][BFPMANSIZE:0]   bfps
);

  logic [FPEXPSIZE-1:0] max_exp;
  logic [FPEXPSIZE-1:0] exp_inc;
  logic                 unused_man_bits;

  always_comb begin
    max_exp = '0;
    for (int k = 0; k < GRPSIZE; k++) begin
      if (exps[k] > max_exp) max_exp = exps[k];
    end
  end

  assign exp_inc = max_exp + FPEXPSIZE'(1);
  assign bfp_exp = BFPEXPSIZE'(exp_inc);

  for (genvar k = 0; k < GRPSIZE; k++) begin : g_elem
    logic [FPEXPSIZE-1:0]  shift;
    logic [BFPMANSIZE-1:0] sig;
    logic [BFPMANSIZE-1:0] mag;

    assign shift = max_exp - exps[k];
    // Significand 1.m sits one place below the shared exponent when at max.
    assign sig   = {1'b1, mans[k][FPMANSIZE-1 -: BFPMANSIZE-1]};
    assign mag   = sig >> shift;
    // Exponent zero (zero/denormal and padding) maps to an all-zero word.
    assign bfps[k] = (exps[k] == '0) ? '0 : {mans[k][FPMANSIZE], mag};
  end

  assign unused_man_bits = ^mans;

endmodule

// File: rtl/bfp_group_sequencer.sv
// Streaming front-end: buffers FP32 elements into a group, converts it to BFP
// and hands the registered group downstream over a valid/ready handshake.
module bfp_group_sequencer
  import bfp_pkg::*;
#(
  parameter int unsigned GRPSIZE    = DEF_GRPSIZE,
  parameter int unsigned FPEXPSIZE  = DEF_FPEXPSIZE,
  parameter int unsigned FPMANSIZE  = DEF_FPMANSIZE,
  parameter int unsigned BFPEXPSIZE = DEF_BFPEXPSIZE,
  parameter int unsigned BFPMANSIZE = DEF_BFPMANSIZE
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [FPEXPSIZE-1:0]               i_exp,
  input  logic [FPMANSIZE:0]                 i_man,
  input  logic                               i_last,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [BFPEXPSIZE-1:0]              o_bfp_exp,
  output logic [GRPSIZE-1:0][BFPMANSIZE:0]   o_bfps,
  output logic [$clog2(GRPSIZE):0]           o_count,
  output logic                               o_sat
);

  localparam int unsigned CW = $clog2(GRPSIZE);
  localparam logic [FPEXPSIZE-1:0] EXP_CLAMP = {{(FPEXPSIZE-1){1'b1}}, 1'b0};

  state_t state_q, state_d;
  logic [CW:0] cnt_q;
  logic        sat_q;

  logic [GRPSIZE-1:0][FPEXPSIZE-1:0] exp_buf;
  logic [GRPSIZE-1:0][FPMANSIZE:0]   man_buf;
  logic [GRPSIZE-1:0][FPEXPSIZE-1:0] conv_exps;
  logic [GRPSIZE-1:0][FPMANSIZE:0]   conv_mans;
  logic [BFPEXPSIZE-1:0]             conv_exp;
  logic [GRPSIZE-1:0][BFPMANSIZE:0]  conv_bfps;

  logic                 accept;
  logic                 closing;
  logic                 in_sat;
  logic                 out_done;
  logic [FPEXPSIZE-1:0] wr_exp;

  assign o_ready  = (state_q == FILL);
  assign o_valid  = (state_q == OUT);
  assign accept   = i_valid && o_ready;
  assign in_sat   = (i_exp == '1);
  assign wr_exp   = in_sat ? EXP_CLAMP : i_exp;
  assign closing  = accept && (i_last || (cnt_q == (CW + 1)'(GRPSIZE - 1)));
  assign out_done = o_valid && i_ready;

  // Stale slots are never cleared; the count mask below hides them.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      exp_buf[cnt_q[CW-1:0]] <= wr_exp;
      man_buf[cnt_q[CW-1:0]] <= i_man;
    end
  end

  for (genvar k = 0; k < GRPSIZE; k++) begin : g_mask
    localparam logic [CW:0] Idx = (CW + 1)'(k);
    assign conv_exps[k] = (Idx < cnt_q) ? exp_buf[k] : '0;
    assign conv_mans[k] = (Idx < cnt_q) ? man_buf[k] : '0;
  end

  bfp_converter #(
    .GRPSIZE    (GRPSIZE),
    .FPEXPSIZE  (FPEXPSIZE),
    .FPMANSIZE  (FPMANSIZE),
    .BFPEXPSIZE (BFPEXPSIZE),
    .BFPMANSIZE (BFPMANSIZE)
  ) u_conv (
    .exps    (conv_exps),
    .mans    (conv_mans),
    .bfp_exp (conv_exp),
    .bfps    (conv_bfps)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (closing) state_d = CONV;
      CONV:    state_d = OUT;
      OUT:     if (i_ready) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      o_bfp_exp <= '0;
      o_bfps    <= '0;
      o_count   <= '0;
      o_sat     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= cnt_q + (CW + 1)'(1);
      end else if (out_done) begin
        cnt_q <= '0;
      end
      if (accept && in_sat) begin
        sat_q <= 1'b1;
      end else if (out_done) begin
        sat_q <= 1'b0;
      end
      if (state_q == CONV) begin
        o_bfp_exp <= conv_exp;
        o_bfps    <= conv_bfps;
        o_count   <= cnt_q;
        o_sat     <= sat_q;
      end
    end
  end

endmodule

// File: doc/bfp_group_sequencer.md
# bfp_group_sequencer

Streaming front-end for `bfp_converter`: accepts FP32 elements one per cycle over a valid/ready handshake and collects them into a GRPSIZE-entry group buffer. It then drives the combinational converter, registers the shared exponent and the GRPSIZE BFP words, and presents the whole group downstream over a second valid/ready handshake. It sits between the FP activation stream and the BFP MAC array input.

## Interface
- GRPSIZE, 16, elements per BFP group (power of two, ≥2)
- FPEXPSIZE, 8, input exponent width
- FPMANSIZE, 23, input mantissa width (sign carried separately as MSB of i_man)
- BFPEXPSIZE, 8, shared exponent width
- BFPMANSIZE, 3, BFP mantissa width (output word = sign + BFPMANSIZE)

- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_valid  in  1  input element valid
- o_ready  out  1  sequencer accepts an element this cycle
- i_exp  in  FPEXPSIZE  biased exponent
- i_man  in  FPMANSIZE+1  {sign, mantissa}
- i_last  in  1  qualifies i_valid; closes a partial group
- o_valid  out  1  group output valid
- i_ready  in  1  downstream accepts group
- o_bfp_exp  out  BFPEXPSIZE  shared exponent
- o_bfps  out  GRPSIZE x (BFPMANSIZE+1)  {sign, mantissa} per element
- o_count  out  $clog2(GRPSIZE)+1  number of real elements in group (1..GRPSIZE)
- o_sat  out  1  at least one element exponent was clamped

## Operation
- States: FILL, CONV, OUT. Reset state FILL.
- FILL: o_ready=1. On i_valid&&o_ready, write element to slot wr_idx and increment wr_idx. Go to CONV when the accepted element fills slot GRPSIZE-1 or has i_last=1; otherwise stay.
- Exponent clamp on write: i_exp == all-ones becomes all-ones−1, and the group's sat flag is set. The converter's +1 then cannot wrap to 0.
- Converter inputs: slot k < count feeds buffer contents; slot k ≥ count feeds exp=0, man=0. Padding never raises the max exponent, and padded outputs are 0.
- CONV: o_ready=0. Register converter outputs into o_bfp_exp/o_bfps, count into o_count and sat into o_sat. Go to OUT.
- OUT: o_ready=0, o_valid=1. All outputs stay stable until i_valid... correction: until i_ready=1. On i_ready, go to FILL with wr_idx=0 and sat=0.
- i_last with i_valid=0 is ignored.
- A group is never empty: CONV is only entered on an accepted element.

## Timing
- Reset (async assert) values: state FILL, wr_idx 0, sat 0, o_valid 0, o_bfp_exp 0, all o_bfps 0, o_count 0, o_sat 0.
- o_ready is combinational from state; it is 1 in FILL, including during reset, but no transfer occurs while i_rst_n=0.
- Latency: the element closing a group is accepted at edge t. o_valid rises after edge t+1 (CONV at t+1) and is visible the cycle after CONV.
- Stated as: accept at cycle n, o_valid=1 from cycle n+2.
- Throughput: a group of N elements occupies at least N+2 cycles, with o_ready low for at least 2 cycles between groups.
- Handshake rules:
  - Upstream must hold i_exp/i_man/i_last while i_valid && !o_ready.
  - The sequencer holds all group outputs while o_valid && !i_ready.
  - Output handshake at cycle m gives o_ready=1 at cycle m+1.
- Reset mid-operation: any partial or pending group is discarded and o_valid drops asynchronously. After reset, the next element goes to slot 0.
- Buffer contents are not cleared between groups; stale slots are hidden by the count mask.

## Structure
- Package bfp_pkg:
  - state typedef enum (FILL, CONV, OUT)
  - default parameter constants
  - clamp constant EXP_MAX = 2**FPEXPSIZE−2
- One sub-module: bfp_converter, instantiated once and fed from the masked buffer.
- Buffer, counter, FSM and output registers are local to bfp_group_sequencer.

## Test plan
- Full group:
  - Stimulus: 16 back-to-back elements, element k has exp=120+k, man=0, sign=0; i_ready=1.
  - Response: o_valid 2 cycles after the 16th accept; o_bfp_exp=136, o_count=16, o_bfps[15]=4'b0100, o_bfps[14]=4'b0010, o_sat=0.
- Partial group:
  - Stimulus: 5 elements with exp=127, i_last on the 5th.
  - Response: o_count=5, o_bfp_exp=128, o_bfps[0..4]=4'b0100, o_bfps[5..15]=0.
- Backpressure:
  - Stimulus: i_ready=0 for 10 cycles in OUT.
  - Response: o_valid stays 1, outputs bit-stable, o_ready=0. Release i_ready → o_ready=1 the next cycle.
- Clamp:
  - Stimulus: one element with exp=8'hFF in a group with all others exp=10.
  - Response: o_bfp_exp=8'hFF, o_sat=1. The next group has o_sat=0.
- Reset mid-fill:
  - Stimulus: assert i_rst_n=0 after 7 accepts, then release and send a full group of exp=127.
  - Response: no output for the aborted group; the new group gives o_count=16, o_bfp_exp=128.
- Back-to-back:
  - Stimulus: 32-element continuous stream.
  - Response: two groups emitted with correct values, o_ready low exactly 2 cycles between groups when i_ready=1.
